prio_level_stack: RTL
=====================

# prio_level_stack

Interrupt nesting controller that owns the active priority level consumed by the banked register file stack. Accepts interrupt requests from the arbiter and return-from-interrupt events from the core. Pushes the preempted level on entry and pops it on return. Drives `level` and the one-cycle return-address capture strobe into the register file, so it is the writer side of that interface.

## Interface
- PrioNum, 8, number of priority levels; level 0 is thread/base level.
- PrioWidth, $clog2(PrioNum), width of a priority value.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- irq_req  in  1  interrupt pending from arbiter, level-sensitive.
- irq_prio  in  PrioWidth  priority of the pending request.
- ret_req  in  1  return-from-interrupt retired this cycle, single-cycle pulse.
- level  out  PrioWidth  current running priority level.
- write_ra_en  out  1  one-cycle strobe that captures the magic return address in the preempted bank.
- irq_ack  out  1  one-cycle pulse when a request is taken.
- ret_ack  out  1  one-cycle pulse when a return is performed.
- depth  out  PrioWidth  nesting depth: number of stacked levels.
- underflow  out  1  sticky flag: ret_req received at depth 0.

## Operation
- FSM states:
  - RUN: idle/executing.
  - ENTER: one-cycle entry window.
  - EXIT: one-cycle exit window.
- Take condition: state RUN, irq_req=1, irq_prio > level, ret_req=0.
- Entry, RUN -> ENTER:
  - push the current level onto the LIFO.
  - level <= irq_prio.
  - depth <= depth+1.
- ENTER: irq_ack=1, write_ra_en=1; next state RUN unconditionally.
- Return condition: state RUN, ret_req=1, depth > 0.
- Return, RUN -> EXIT:
  - level <= popped value.
  - depth <= depth-1.
- EXIT: ret_ack=1; next state RUN.
- ret_req with depth 0 in RUN: ignored; underflow <= 1 (cleared only by reset).
- Simultaneous ret_req and eligible irq_req: the return wins. The request is re-evaluated in RUN against the popped level, giving tail-chaining in 2 cycles.
- Requests with irq_prio <= level are never taken; irq_prio=0 is never taken.
- irq_req or ret_req arriving in ENTER or EXIT is not sampled. The core holds irq_req; ret_req in these states is dropped and counts as a protocol error covered by assertion.
- LIFO capacity is PrioNum-1 entries. Strictly increasing levels make overflow unreachable; an assertion checks push with depth=PrioNum-1.
- depth arithmetic is unsigned PrioWidth bits, with no wrap in legal operation.

## Timing
- Reset (synchronous, takes priority over everything):
  - level=0, depth=0, all pulses 0, underflow=0, state RUN.
  - LIFO contents are don't-care.
- Reset asserted during ENTER or EXIT aborts the operation: no ack is issued in the following cycle.
- Entry latency: request sampled at edge N. level, depth and ENTER are visible after edge N+1, with irq_ack and write_ra_en high for that cycle only. The next take is possible at edge N+2.
- Return latency: ret_req sampled at edge N. The new level and ret_ack are visible after edge N+1. RUN is reached after edge N+2.
- write_ra_en is asserted while level already shows the new level. The register file indexes the preempted bank as its registered level, so no extra alignment is done here.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- config_pkg already holds PrioNum, PrioWidth and PrioT. Add LevelStateT (RUN, ENTER, EXIT) to it.
- Sub-module prio_lifo: PrioT-wide, PrioNum-1 deep LIFO.
  - Ports: push, pop, din, dout, count.
  - Synchronous reset clears count.
  - Push and pop in the same cycle never happen and are covered by assertion.
- Top level: FSM, level register, sticky flag, and one prio_lifo instance.

## Test plan
- Reset then idle: level=0, depth=0, all strobes 0 for 10 cycles with irq_req=0.
- Single entry/return:
  - irq_req=1, irq_prio=3 at level 0 -> next cycle level=3, irq_ack=1, write_ra_en=1, depth=1.
  - ret_req pulse -> next cycle level=0, ret_ack=1, depth=0.
- Nesting:
  - take prio 2, then prio 5 -> level 5, depth 2.
  - request prio 4 -> not taken.
  - two returns -> level 2 then 0.
- Simultaneous at level 2 (depth 1): ret_req with irq_req prio 6 held -> cycle 1 level 0 with ret_ack; 2 cycles later level 6 with irq_ack (tail-chain).
- ret_req at depth 0 -> level stays 0, underflow=1 and stays 1 until reset.
- Reset asserted in the ENTER cycle after taking prio 7 -> next cycle level=0, depth=0, no irq_ack.

Source files
------------

// File: rtl/config_pkg.sv
// config_pkg: shared priority sizing and the nesting controller state encoding
package config_pkg;
  localparam int PrioNum = 8;
  localparam int PrioWidth = $clog2(PrioNum);
  typedef logic [PrioWidth-1:0] PrioT;
  typedef enum logic [1:0] {RUN, ENTER, EXIT} LevelStateT;
endpackage

// File: rtl/prio_level_stack_lifo.sv
// prio_lifo: stack of preempted priority levels, one entry per nesting step
module prio_lifo
  import config_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [PrioWidth-1:0] din,
  output logic [PrioWidth-1:0] dout,
  output logic [PrioWidth-1:0] count
);
  PrioT mem [PrioNum-1];
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (push) count <= count + 1'b1;
    else if (pop) count <= count - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (push) mem[count] <= din;
  end
  assign dout = mem[count - 1'b1];
  a_no_push_pop: assert property (@(posedge clk) disable iff (reset) !(push && pop));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && count == PrioWidth'(PrioNum - 1)));
endmodule

// File: rtl/prio_level_stack.sv
// prio_level_stack: interrupt nesting controller driving the active priority level
module prio_level_stack
  import config_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 irq_req,
  input  logic [PrioWidth-1:0] irq_prio,
  input  logic                 ret_req,
  output logic [PrioWidth-1:0] level,
  output logic                 write_ra_en,
  output logic                 irq_ack,
  output logic                 ret_ack,
  output logic [PrioWidth-1:0] depth,
  output logic                 underflow
);
  LevelStateT state, state_d;
  logic take, ret_do;
  logic [PrioWidth-1:0] popped;
  // a return always beats a simultaneous request; the request is re-evaluated afterwards
  assign take   = state == RUN && irq_req && irq_prio > level && !ret_req;
  assign ret_do = state == RUN && ret_req && depth != '0;
  always_comb begin
    state_d = RUN;
    state_d = take ? ENTER : ret_do ? EXIT : RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      level     <= '0;
      underflow <= 1'b0;
    end else begin
      state     <= state_d;
      level     <= take ? irq_prio : ret_do ? popped : level;
      underflow <= underflow | (state == RUN && ret_req && depth == '0);
    end
  end
  assign irq_ack     = state == ENTER;
  assign write_ra_en = state == ENTER;
  assign ret_ack     = state == EXIT;
  prio_lifo u_lifo (
    .clk   (clk),
    .reset (reset),
    .push  (take),
    .pop   (ret_do),
    .din   (level),
    .dout  (popped),
    .count (depth)
  );
  a_ret_in_run: assert property (@(posedge clk) disable iff (reset) state != RUN |-> !ret_req);
endmodule
